cp0_regfile_w: RTL and testbench

- CP0 register file at the write-back stage of the MIPS32 pipeline.
- Consumes the 30-bit WB control bus and exception state produced by the W-stage control decoder.
- Holds BadVAddr, Count, Compare, Status, Cause and EPC, and serves MFC0 reads.
- Commits exceptions, interrupts and ERET, and issues the flush/redirect to fetch.

---
 rtl/cp0_pkg.sv | 57 +++++
 rtl/cp0_regfile_w_timer.sv | 56 +++++
 rtl/cp0_regfile_w.sv | 128 ++++++++++++
 tb/tb_cp0_regfile_w.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cp0_pkg
// Description : Shared constants, field indices and ExcCode table for CP0 (W)
// Revision    : 1.0 - initial release
// ============================================================================
package cp0_pkg;

  // MFC0/MTC0 register addresses (sel=0)
  localparam logic [4:0] c_addr_badvaddr = 5'd8;
  localparam logic [4:0] c_addr_count    = 5'd9;
  localparam logic [4:0] c_addr_compare  = 5'd11;
  localparam logic [4:0] c_addr_status   = 5'd12;
  localparam logic [4:0] c_addr_cause    = 5'd13;
  localparam logic [4:0] c_addr_epc      = 5'd14;

  // wb_ctrl bit positions
  localparam int unsigned c_wb_pc_choice       = 29;
  localparam int unsigned c_wb_cp0_choice      = 28;
  localparam int unsigned c_wb_badaddr_wden    = 27;
  localparam int unsigned c_wb_badaddr_choice  = 26;
  localparam int unsigned c_wb_cause_bd_choice = 21;
  localparam int unsigned c_wb_exccode_hi      = 18;
  localparam int unsigned c_wb_exccode_lo      = 16;
  localparam int unsigned c_wb_cp0dsel         = 7;

  // Status fields
  localparam int unsigned c_status_ie  = 0;
  localparam int unsigned c_status_exl = 1;

  localparam logic [31:0] c_status_wmask = 32'h0000_FF03;
  localparam logic [31:0] c_exc_vector   = 32'hBFC0_0380;
  localparam logic [31:0] c_status_rst   = 32'h0040_0000;

  typedef struct packed {
    logic       valid;
    logic [4:0] code;
  } exc_code_t;

  function automatic exc_code_t exc_code_lookup(input logic [2:0] choice);
    exc_code_t res;
    res.valid = 1'b1;
    res.code  = 5'd0;
    case (choice)
      3'b001:  res.code = 5'd4;
      3'b010:  res.code = 5'd5;
      3'b011:  res.code = 5'd8;
      3'b100:  res.code = 5'd9;
      3'b101:  res.code = 5'd10;
      3'b110:  res.code = 5'd12;
      default: res.valid = 1'b0;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_regfile_w_timer.sv
`default_nettype none
// ============================================================================
// Module      : cp0_timer
// Description : Count (half-rate), Compare and the sticky timer-interrupt flag
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_toggle;
  logic        r_ti;
  logic        w_match;

  assign w_match = (r_count == r_compare) && (r_compare != 32'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= 32'd0;
      r_compare <= 32'd0;
      r_toggle  <= 1'b0;
      r_ti      <= 1'b0;
    end else begin
      // A software Count write restarts the half-rate phase
      if (count_we) begin
        r_count  <= wdata;
        r_toggle <= 1'b0;
      end else begin
        r_toggle <= ~r_toggle;
        if (r_toggle) r_count <= r_count + 32'd1;
      end

      if (compare_we) begin
        r_compare <= wdata;
        r_ti      <= 1'b0;
      end else if (w_match) begin
        r_ti <= 1'b1;
      end
    end
  end

  assign count   = r_count;
  assign compare = r_compare;
  assign ti      = r_ti;

endmodule
`default_nettype wire

// File: rtl/cp0_regfile_w.sv
`default_nettype none
// ============================================================================
// Module      : cp0_regfile_w
// Description : W-stage CP0 register file with exception/interrupt/ERET commit
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_regfile_w
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = c_exc_vector,
  parameter logic [31:0] STATUS_RST = c_status_rst
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        w_valid,
  input  logic [29:0] wb_ctrl,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  input  logic [31:0] pc_W,
  input  logic [31:0] mem_addr_W,
  input  logic [5:0]  hw_int,
  output logic [31:0] cp0_rdata,
  output logic        flush_W,
  output logic [31:0] redirect_pc,
  output logic        int_taken
);

  logic [31:0] r_badvaddr;
  logic [31:0] r_status;
  logic [31:0] r_epc;
  logic        r_cause_bd;
  logic [4:0]  r_exc_code;
  logic [7:0]  r_ip;

  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_ti;
  logic [31:0] w_cause;

  logic        w_exc;
  logic        w_intr;
  logic        w_eret;
  logic        w_mtc0;
  logic        w_trap;
  logic        w_bd;
  logic [31:0] w_trap_epc;
  exc_code_t   w_code;
  logic        w_unused;

  assign w_exc  = w_valid & wb_ctrl[c_wb_cp0_choice];
  assign w_intr = w_valid & ~w_exc & r_status[c_status_ie] & ~r_status[c_status_exl]
                & (|(r_ip & r_status[15:8]));
  assign w_eret = w_valid & wb_ctrl[c_wb_pc_choice] & ~w_exc & ~w_intr;
  assign w_mtc0 = w_valid & wb_ctrl[c_wb_cp0dsel] & ~w_exc & ~w_intr;
  assign w_trap = w_exc | w_intr;

  assign w_bd       = wb_ctrl[c_wb_cause_bd_choice];
  assign w_trap_epc = w_bd ? (pc_W - 32'd4) : pc_W;
  assign w_code     = exc_code_lookup(wb_ctrl[c_wb_exccode_hi:c_wb_exccode_lo]);

  // Write-enable/choice bits not needed because commit is decided by event type
  assign w_unused = ^{wb_ctrl[25:22], wb_ctrl[20:19], wb_ctrl[15:8], wb_ctrl[6:0]};

  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (w_mtc0 && (cp0_addr == c_addr_count)),
    .compare_we (w_mtc0 && (cp0_addr == c_addr_compare)),
    .wdata      (cp0_wdata),
    .count      (w_count),
    .compare    (w_compare),
    .ti         (w_ti)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_badvaddr <= 32'd0;
      r_status   <= STATUS_RST;
      r_epc      <= 32'd0;
      r_cause_bd <= 1'b0;
      r_exc_code <= 5'd0;
      r_ip       <= 8'd0;
    end else begin
      // Hardware interrupt lines are sampled every cycle, valid or not
      r_ip[7:2] <= {hw_int[5] | w_ti, hw_int[4:0]};
      if (w_mtc0 && (cp0_addr == c_addr_cause)) r_ip[1:0] <= cp0_wdata[9:8];

      if (w_trap) begin
        r_epc                  <= w_trap_epc;
        r_cause_bd             <= w_bd;
        r_status[c_status_exl] <= 1'b1;
        if (w_intr)            r_exc_code <= 5'd0;
        else if (w_code.valid) r_exc_code <= w_code.code;
        if (w_exc && wb_ctrl[c_wb_badaddr_wden])
          r_badvaddr <= wb_ctrl[c_wb_badaddr_choice] ? mem_addr_W : pc_W;
      end else if (w_eret) begin
        r_status[c_status_exl] <= 1'b0;
      end else if (w_mtc0) begin
        case (cp0_addr)
          c_addr_status: r_status <= (r_status & ~c_status_wmask) | (cp0_wdata & c_status_wmask);
          c_addr_epc:    r_epc    <= cp0_wdata;
          default: ;
        endcase
      end
    end
  end

  assign w_cause = {r_cause_bd, w_ti, 14'd0, r_ip, 1'b0, r_exc_code, 2'b00};

  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      c_addr_badvaddr: cp0_rdata = r_badvaddr;
      c_addr_count:    cp0_rdata = w_count;
      c_addr_compare:  cp0_rdata = w_compare;
      c_addr_status:   cp0_rdata = r_status;
      c_addr_cause:    cp0_rdata = w_cause;
      c_addr_epc:      cp0_rdata = r_epc;
      default:         cp0_rdata = 32'd0;
    endcase
  end

  assign flush_W     = ~rst & (w_trap | w_eret);
  assign int_taken   = ~rst & w_intr;
  assign redirect_pc = w_trap ? EXC_VECTOR : (w_eret ? r_epc : 32'd0);

endmodule
`default_nettype wire

// File: tb/tb_cp0_regfile_w.sv
`default_nettype none
// ============================================================================
// Module      : tb_cp0_regfile_w
// Description : Directed + randomized bench for cp0_regfile_w with a CP0 model
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_regfile_w;

  logic        clk = 1'b0;
  logic        rst;
  logic        w_valid;
  logic [29:0] wb_ctrl;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] pc_W;
  logic [31:0] mem_addr_W;
  logic [5:0]  hw_int;
  logic [31:0] cp0_rdata;
  logic        flush_W;
  logic [31:0] redirect_pc;
  logic        int_taken;

  int total = 0;
  int bad   = 0;

  cp0_regfile_w dut (
    .clk(clk), .rst(rst), .w_valid(w_valid), .wb_ctrl(wb_ctrl),
    .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata), .pc_W(pc_W),
    .mem_addr_W(mem_addr_W), .hw_int(hw_int), .cp0_rdata(cp0_rdata),
    .flush_W(flush_W), .redirect_pc(redirect_pc), .int_taken(int_taken)
  );

  always #5 clk = ~clk;

  // Reference model: architectural state; Count kept as base + elapsed/2
  logic [31:0] m_badv, m_cnt_base, m_compare, m_status, m_epc;
  int unsigned m_elapsed;
  logic        m_bd, m_ti;
  logic [4:0]  m_code;
  logic [7:0]  m_ip;
  int          code_tab [8] = '{0, 4, 5, 8, 9, 10, 12, 0};

  logic        e_flush, e_int, e_exc, e_intr, e_eret, e_mtc0;
  logic [31:0] e_redirect, e_rdata;

  function automatic logic [31:0] m_count();
    return m_cnt_base + 32'(m_elapsed / 2);
  endfunction

  function automatic logic [31:0] m_cause();
    return {m_bd, m_ti, 14'd0, m_ip, 1'b0, m_code, 2'b00};
  endfunction

  task automatic predict();
    e_exc  = w_valid && wb_ctrl[28];
    e_intr = w_valid && !e_exc && m_status[0] && !m_status[1] && ((m_ip & m_status[15:8]) != 8'd0);
    e_eret = w_valid && wb_ctrl[29] && !e_exc && !e_intr;
    e_mtc0 = w_valid && wb_ctrl[7] && !e_exc && !e_intr;
    e_flush = !rst && (e_exc || e_intr || e_eret);
    e_int   = !rst && e_intr;
    e_redirect = (e_exc || e_intr) ? 32'hBFC0_0380 : (e_eret ? m_epc : 32'd0);
    case (cp0_addr)
      5'd8:    e_rdata = m_badv;
      5'd9:    e_rdata = m_count();
      5'd11:   e_rdata = m_compare;
      5'd12:   e_rdata = m_status;
      5'd13:   e_rdata = m_cause();
      5'd14:   e_rdata = m_epc;
      default: e_rdata = 32'd0;
    endcase
  endtask

  // Advance one clock, moving the model by the same rules
  task automatic step();
    logic [31:0] cnt;
    logic [7:0]  n_ip;
    logic [2:0]  ch;
    predict();
    if (rst) begin
      m_badv = 0; m_cnt_base = 0; m_elapsed = 0; m_compare = 0;
      m_status = 32'h0040_0000; m_epc = 0; m_bd = 0; m_ti = 0; m_code = 0; m_ip = 0;
    end else begin
      cnt  = m_count();
      n_ip = {hw_int[5] | m_ti, hw_int[4:0], m_ip[1:0]};
      if (e_mtc0 && cp0_addr == 5'd13) n_ip[1:0] = cp0_wdata[9:8];
      if (e_mtc0 && cp0_addr == 5'd11) begin
        m_compare = cp0_wdata; m_ti = 0;
      end else if (cnt == m_compare && m_compare != 0) m_ti = 1;
      if (e_mtc0 && cp0_addr == 5'd9) begin
        m_cnt_base = cp0_wdata; m_elapsed = 0;
      end else m_elapsed++;
      if (e_exc || e_intr) begin
        m_epc = wb_ctrl[21] ? pc_W - 4 : pc_W;
        m_bd  = wb_ctrl[21];
        m_status[1] = 1'b1;
        ch = wb_ctrl[18:16];
        if (e_intr) m_code = 0;
        else if (ch != 0 && ch != 7) m_code = 5'(code_tab[ch]);
        if (e_exc && wb_ctrl[27]) m_badv = wb_ctrl[26] ? mem_addr_W : pc_W;
      end else if (e_eret) m_status[1] = 1'b0;
      else if (e_mtc0) begin
        if (cp0_addr == 5'd12) m_status = (m_status & ~32'h0000_FF03) | (cp0_wdata & 32'h0000_FF03);
        if (cp0_addr == 5'd14) m_epc = cp0_wdata;
      end
      m_ip = n_ip;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; w_valid = 0; wb_ctrl = 0; cp0_addr = 0; cp0_wdata = 0;
    pc_W = 0; mem_addr_W = 0; hw_int = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    #2;
    total++; if (flush_W !== 1'b0 || int_taken !== 1'b0) begin bad++; $display("FAIL reset_outputs flush=%b int=%b want 0 0", flush_W, int_taken); end
    step();
    rst = 0;
    cp0_addr = 12; #2;
    total++; if (cp0_rdata !== 32'h0040_0000) begin bad++; $display("FAIL reset_status got=%h want=00400000", cp0_rdata); end
    for (int i = 0; i < 10; i++) step();
    cp0_addr = 9; #2;
    total++; if (cp0_rdata !== 32'd5) begin bad++; $display("FAIL idle_count got=%0d want=5", cp0_rdata); end
    total++; if (flush_W !== 1'b0) begin bad++; $display("FAIL idle_flush got=%b want=0", flush_W); end
  endtask

  task automatic test_exception();
    idle();
    w_valid = 1; wb_ctrl[28] = 1; wb_ctrl[18:16] = 3'b110; wb_ctrl[21] = 1; pc_W = 32'h1000;
    #2;
    total++; if (flush_W !== 1'b1 || redirect_pc !== 32'hBFC0_0380 || int_taken !== 1'b0) begin
      bad++; $display("FAIL exc_flush flush=%b pc=%h int=%b want 1 bfc00380 0", flush_W, redirect_pc, int_taken); end
    step();
    idle();
    cp0_addr = 14; #2;
    total++; if (cp0_rdata !== 32'h0FFC) begin bad++; $display("FAIL exc_epc got=%h want=00000ffc", cp0_rdata); end
    cp0_addr = 13; #1;
    total++; if (cp0_rdata !== 32'h8000_0030) begin bad++; $display("FAIL exc_cause got=%h want=80000030", cp0_rdata); end
    cp0_addr = 12; #1;
    total++; if (cp0_rdata !== 32'h0040_0002) begin bad++; $display("FAIL exc_exl got=%h want=00400002", cp0_rdata); end
    step();
  endtask

  task automatic test_adel();
    idle();
    w_valid = 1; wb_ctrl[28] = 1; wb_ctrl[27] = 1; wb_ctrl[26] = 1; wb_ctrl[18:16] = 3'b001;
    wb_ctrl[7] = 1; cp0_addr = 14; cp0_wdata = 32'hDEAD_BEEF; pc_W = 32'h3000; mem_addr_W = 32'h2001;
    #2;
    total++; if (cp0_rdata !== 32'h0FFC) begin bad++; $display("FAIL adel_preread got=%h want=00000ffc", cp0_rdata); end
    step();
    idle();
    cp0_addr = 8; #2;
    total++; if (cp0_rdata !== 32'h2001) begin bad++; $display("FAIL adel_badv got=%h want=00002001", cp0_rdata); end
    cp0_addr = 14; #1;
    total++; if (cp0_rdata !== 32'h3000) begin bad++; $display("FAIL adel_epc got=%h want=00003000", cp0_rdata); end
    cp0_addr = 13; #1;
    total++; if (cp0_rdata !== 32'h0000_0010) begin bad++; $display("FAIL adel_cause got=%h want=00000010", cp0_rdata); end
    step();
  endtask

  task automatic test_status_eret();
    idle();
    w_valid = 1; wb_ctrl[7] = 1; cp0_addr = 12; cp0_wdata = 32'hFFFF_FFFF;
    step();
    idle();
    cp0_addr = 12; #2;
    total++; if (cp0_rdata !== 32'h0040_FF03) begin bad++; $display("FAIL status_mask got=%h want=0040ff03", cp0_rdata); end
    w_valid = 1; wb_ctrl[29] = 1; #1;
    total++; if (flush_W !== 1'b1 || redirect_pc !== 32'h3000) begin
      bad++; $display("FAIL eret_redirect flush=%b pc=%h want 1 00003000", flush_W, redirect_pc); end
    step();
    w_valid = 0; #2;
    total++; if (cp0_rdata !== 32'h0040_FF01) begin bad++; $display("FAIL eret_exl got=%h want=0040ff01", cp0_rdata); end
    total++; if (flush_W !== 1'b0) begin bad++; $display("FAIL eret_bubble flush=%b want=0", flush_W); end
    step();
  endtask

  task automatic test_timer();
    bit seen;
    idle();
    w_valid = 1; wb_ctrl[7] = 1; cp0_addr = 9; cp0_wdata = 0;
    step();
    cp0_addr = 11; cp0_wdata = 3;
    step();
    idle();
    seen = 0;
    cp0_addr = 13;
    for (int i = 0; i < 20 && !seen; i++) begin
      #2; if (cp0_rdata[30] && cp0_rdata[15]) seen = 1; else step();
    end
    total++; if (!seen) begin bad++; $display("FAIL timer_ti_timeout cause=%h want bit30 and bit15 set", cp0_rdata); end
    w_valid = 1; pc_W = 32'h4000; #1;
    total++; if (int_taken !== 1'b1 || flush_W !== 1'b1 || redirect_pc !== 32'hBFC0_0380) begin
      bad++; $display("FAIL timer_int int=%b flush=%b pc=%h want 1 1 bfc00380", int_taken, flush_W, redirect_pc); end
    step();
    idle();
    cp0_addr = 14; #2;
    total++; if (cp0_rdata !== 32'h4000) begin bad++; $display("FAIL int_epc got=%h want=00004000", cp0_rdata); end
    cp0_addr = 13; #1;
    total++; if (cp0_rdata[6:2] !== 5'd0 || cp0_rdata[31] !== 1'b0) begin bad++; $display("FAIL int_cause got=%h want code 0 bd 0", cp0_rdata); end
    w_valid = 1; wb_ctrl[7] = 1; cp0_addr = 11; cp0_wdata = 0;
    step();
    idle();
    cp0_addr = 13; #2;
    total++; if (cp0_rdata[30] !== 1'b0) begin bad++; $display("FAIL ti_clear got=%h want bit30=0", cp0_rdata); end
    step();
  endtask

  task automatic test_random();
    logic [4:0] addrs [7] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0};
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 63) == 0);
      w_valid    = ($urandom_range(0, 3) != 0);
      wb_ctrl    = 30'($urandom);
      wb_ctrl[28] = ($urandom_range(0, 7) == 0);
      wb_ctrl[29] = ($urandom_range(0, 7) == 0);
      wb_ctrl[7]  = !wb_ctrl[29] && ($urandom_range(0, 2) == 0);
      if (wb_ctrl[18:16] == 3'b000) wb_ctrl[18:16] = 3'b001;
      cp0_addr   = addrs[$urandom_range(0, 6)];
      if (cp0_addr == 0) cp0_addr = 5'($urandom);
      cp0_wdata  = $urandom_range(0, 1) ? 32'($urandom_range(0, 7)) : $urandom;
      pc_W       = $urandom & 32'hFFFF_FFFC;
      mem_addr_W = $urandom;
      hw_int     = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      #2;
      predict();
      total++; if (flush_W !== e_flush) begin bad++; $display("FAIL rnd_flush i=%0d got=%b want=%b", i, flush_W, e_flush); end
      total++; if (int_taken !== e_int) begin bad++; $display("FAIL rnd_int i=%0d got=%b want=%b", i, int_taken, e_int); end
      total++; if (cp0_rdata !== e_rdata) begin bad++; $display("FAIL rnd_rdata i=%0d addr=%0d got=%h want=%h", i, cp0_addr, cp0_rdata, e_rdata); end
      if (e_flush) begin
        total++; if (redirect_pc !== e_redirect) begin bad++; $display("FAIL rnd_redirect i=%0d got=%h want=%h", i, redirect_pc, e_redirect); end
      end
      step();
    end
  endtask

  task automatic test_rst_mid();
    logic [4:0]  addrs [6] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14};
    logic [31:0] wants [6] = '{32'd0, 32'd0, 32'd0, 32'h0040_0000, 32'd0, 32'd0};
    idle();
    rst = 1; w_valid = 1; wb_ctrl[28] = 1; wb_ctrl[27] = 1; wb_ctrl[18:16] = 3'b011; pc_W = 32'h7770;
    #2;
    total++; if (flush_W !== 1'b0 || int_taken !== 1'b0) begin bad++; $display("FAIL rst_mid_outputs flush=%b int=%b want 0 0", flush_W, int_taken); end
    step();
    idle();
    #2;
    for (int k = 0; k < 6; k++) begin
      cp0_addr = addrs[k]; #1;
      total++; if (cp0_rdata !== wants[k]) begin bad++; $display("FAIL rst_mid_reg addr=%0d got=%h want=%h", addrs[k], cp0_rdata, wants[k]); end
    end
  endtask

  initial begin
    idle();
    @(posedge clk); #1;
    test_reset();
    test_exception();
    test_adel();
    test_status_eret();
    test_timer();
    test_random();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
